// File: rtl/hack_logic_pkg.sv
// Shared op codes, FSM state encoding and a small decode helper for the
// bitwise accumulate unit and its combinational operator.
package hack_logic_pkg;

  localparam logic [2:0] OP_AND    = 3'b000;
  localparam logic [2:0] OP_OR     = 3'b001;
  localparam logic [2:0] OP_XOR    = 3'b010;
  localparam logic [2:0] OP_NAND   = 3'b011;
  localparam logic [2:0] OP_NOR    = 3'b100;
  localparam logic [2:0] OP_XNOR   = 3'b101;
  localparam logic [2:0] OP_NOT_B  = 3'b110;
  localparam logic [2:0] OP_PASS_B = 3'b111;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_ACCUM = 1'b1
  } state_t;

  // A packet opens only when accumulation is requested and more beats follow.
  function automatic logic opens_packet(input logic acc, input logic last);
    return acc && !last;
  endfunction

endpackage

// File: rtl/bitwise_op.sv
// Purely combinational WIDTH-bit bitwise operator selected by a 3-bit op code.
module bitwise_op
  import hack_logic_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] z
);

  // Operator select
  always_comb begin
    z = '0;
    case (op)
      OP_AND:    z = x & y;
      OP_OR:     z = x | y;
      OP_XOR:    z = x ^ y;
      OP_NAND:   z = ~(x & y);
      OP_NOR:    z = ~(x | y);
      OP_XNOR:   z = ~(x ^ y);
      OP_NOT_B:  z = ~y;
      OP_PASS_B: z = y;
      default:   z = '0;
    endcase
  end

endmodule

// File: rtl/bitwise_acc_unit.sv
// Pipelined bitwise logic unit with packet accumulation over a valid/ready stream.
// Define BITWISE_ACC_FLAGS_EN to add the registered out_zr/out_ng status flags.
module bitwise_acc_unit
  import hack_logic_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [2:0]       in_op,
  input  logic             in_acc,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
`ifdef BITWISE_ACC_FLAGS_EN
  ,
  output logic             out_zr,
  output logic             out_ng
`endif
);

  state_t           state_r;
  state_t           state_nxt_s;
  logic [WIDTH-1:0] acc_r;
  logic [WIDTH-1:0] x_s;
  logic [WIDTH-1:0] z_s;
  logic             accept_s;
  logic             produce_s;
  logic             acc_load_s;

  // The single-entry output register can take a new beat whenever it is
  // empty or being drained this cycle, in every state.
  assign in_ready = !out_valid || out_ready;
  assign accept_s = in_valid && in_ready;

  // Operand X comes from the running accumulator while a packet is open
  always_comb begin
    x_s = in_a;
    case (state_r)
      ST_IDLE:  x_s = in_a;
      ST_ACCUM: x_s = acc_r;
      default:  x_s = in_a;
    endcase
  end

  bitwise_op #(.WIDTH(WIDTH)) u_op (
    .op(in_op),
    .x (x_s),
    .y (in_b),
    .z (z_s)
  );

  // Beat classification and next-state decision
  always_comb begin
    produce_s   = 1'b0;
    acc_load_s  = 1'b0;
    state_nxt_s = state_r;
    if (accept_s) begin
      case (state_r)
        ST_IDLE: begin
          if (opens_packet(in_acc, in_last)) begin
            acc_load_s  = 1'b1;
            state_nxt_s = ST_ACCUM;
          end else begin
            produce_s   = 1'b1;
          end
        end
        ST_ACCUM: begin
          if (in_last) begin
            produce_s   = 1'b1;
            state_nxt_s = ST_IDLE;
          end else begin
            acc_load_s  = 1'b1;
          end
        end
        default: begin
          state_nxt_s = ST_IDLE;
        end
      endcase
    end else begin
      state_nxt_s = state_r;
    end
  end

  // FSM, accumulator and output register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r   <= ST_IDLE;
      acc_r     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      state_r <= state_nxt_s;
      if (acc_load_s) begin
        acc_r <= z_s;
      end else begin
        acc_r <= acc_r;
      end
      // A new result overwrites a popped one in the same cycle, no bubble.
      if (produce_s) begin
        out_valid <= 1'b1;
        out_data  <= z_s;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end else begin
        out_valid <= out_valid;
      end
    end
  end

`ifdef BITWISE_ACC_FLAGS_EN
  // Status flags load together with out_data
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_zr <= 1'b0;
      out_ng <= 1'b0;
    end else if (produce_s) begin
      out_zr <= (z_s == '0);
      out_ng <= z_s[WIDTH-1];
    end else begin
      out_zr <= out_zr;
      out_ng <= out_ng;
    end
  end
`endif

endmodule

// File: tb/tb_bitwise_acc_unit.sv
// Self-checking bench: directed WIDTH=16 scenarios plus a WIDTH=8 op sweep and
// randomized handshake run against a packet-level reference model.
module tb_bitwise_acc_unit;
  import hack_logic_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        v16, r16, acc16, last16, ov16, ordy16;
  logic [15:0] a16, b16, d16;
  logic [2:0]  op16;
  logic        v8, r8, acc8, last8, ov8, ordy8;
  logic [7:0]  a8, b8, d8;
  logic [2:0]  op8;
`ifdef BITWISE_ACC_FLAGS_EN
  logic        zr16, ng16, zr8, ng8;
`endif

  int vectors = 0;
  int miscompares = 0;

  bitwise_acc_unit #(.WIDTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(v16), .in_ready(r16),
    .in_a(a16), .in_b(b16), .in_op(op16), .in_acc(acc16), .in_last(last16),
    .out_valid(ov16), .out_ready(ordy16), .out_data(d16)
`ifdef BITWISE_ACC_FLAGS_EN
    , .out_zr(zr16), .out_ng(ng16)
`endif
  );

  bitwise_acc_unit #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(v8), .in_ready(r8),
    .in_a(a8), .in_b(b8), .in_op(op8), .in_acc(acc8), .in_last(last8),
    .out_valid(ov8), .out_ready(ordy8), .out_data(d8)
`ifdef BITWISE_ACC_FLAGS_EN
    , .out_zr(zr8), .out_ng(ng8)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] ref_op(input logic [2:0] op, input logic [15:0] a,
                                         input logic [15:0] b);
    case (op)
      3'd0:    return a & b;
      3'd1:    return a | b;
      3'd2:    return a ^ b;
      3'd3:    return ~(a & b);
      3'd4:    return ~(a | b);
      3'd5:    return ~(a ^ b);
      3'd6:    return ~b;
      3'd7:    return b;
      default: return 16'h0000;
    endcase
  endfunction

  task automatic drive16(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                         input logic acc, input logic last);
    v16 = 1'b1; op16 = op; a16 = a; b16 = b; acc16 = acc; last16 = last;
  endtask

  logic [15:0] pa[3]   = '{16'hAAAA, 16'h1234, 16'h1234};
  logic [15:0] pb[3]   = '{16'h5555, 16'hABCD, 16'hABCD};
  logic [2:0]  pop[3]  = '{3'b000, 3'b000, 3'b010};
  logic [15:0] pexp[3] = '{16'h0000, 16'h0204, 16'hB9F9};

  // Reference model state for the randomized WIDTH=8 phase
  logic       m_valid, m_in_pkt, accept, produce;
  logic [7:0] m_data, m_first, res;
  logic [2:0] q_op[$];
  logic [7:0] q_b[$];

  initial begin
    rst_n = 1'b0;
    v16 = 1'b0; a16 = '0; b16 = '0; op16 = '0; acc16 = 1'b0; last16 = 1'b0; ordy16 = 1'b1;
    v8  = 1'b0; a8  = '0; b8  = '0; op8  = '0; acc8  = 1'b0; last8  = 1'b0; ordy8  = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_valid", 32'(ov16), 32'd0);
    check("rst_data", 32'(d16), 32'd0);
    check("rst_ready", 32'(r16), 32'd1);
`ifdef BITWISE_ACC_FLAGS_EN
    check("rst_zr", 32'(zr16), 32'd0);
    check("rst_ng", 32'(ng16), 32'd0);
`endif
    rst_n = 1'b1;

    // Back-to-back pass-through, one result per cycle
    drive16(pop[0], pa[0], pb[0], 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("pass%0d_valid", i), 32'(ov16), 32'd1);
      check($sformatf("pass%0d_data", i), 32'(d16), 32'(pexp[i]));
`ifdef BITWISE_ACC_FLAGS_EN
      if (i == 0) begin
        check("pass0_zr", 32'(zr16), 32'd1);
        check("pass0_ng", 32'(ng16), 32'd0);
      end
`endif
      if (i < 2) drive16(pop[i+1], pa[i+1], pb[i+1], 1'b0, 1'b1);
      else v16 = 1'b0;
    end
    @(negedge clk);
    check("pass_drain", 32'(ov16), 32'd0);

    // OR accumulate packet: exactly one output after the last beat
    drive16(OP_OR, 16'h0001, 16'h0002, 1'b1, 1'b0);
    @(negedge clk);
    check("acc_b1_nov", 32'(ov16), 32'd0);
    drive16(OP_OR, 16'hFFFF, 16'h0004, 1'b0, 1'b0);
    @(negedge clk);
    check("acc_b2_nov", 32'(ov16), 32'd0);
    drive16(OP_OR, 16'hFFFF, 16'h8000, 1'b1, 1'b1);
    @(negedge clk);
    v16 = 1'b0;
    check("acc_valid", 32'(ov16), 32'd1);
    check("acc_data", 32'(d16), 32'h8007);
    @(negedge clk);
    check("acc_single", 32'(ov16), 32'd0);

    // Backpressure holds result and stalls the queued beat
    ordy16 = 1'b0;
    drive16(OP_AND, 16'h1234, 16'hABCD, 1'b0, 1'b0);
    @(negedge clk);
    drive16(OP_NOR, 16'h0000, 16'h0000, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      #1;
      check("bp_valid", 32'(ov16), 32'd1);
      check("bp_data", 32'(d16), 32'h0204);
      check("bp_ready", 32'(r16), 32'd0);
      @(negedge clk);
    end
    ordy16 = 1'b1;
    @(negedge clk);
    v16 = 1'b0;
    check("bp_rel_valid", 32'(ov16), 32'd1);
    check("bp_rel_data", 32'(d16), 32'hFFFF);
    @(negedge clk);
    check("bp_drain", 32'(ov16), 32'd0);

    // Reset mid-packet discards accumulation and returns to IDLE
    drive16(OP_AND, 16'hFFFF, 16'h0F0F, 1'b1, 1'b0);
    @(negedge clk);
    v16 = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    check("mrst_valid", 32'(ov16), 32'd0);
    rst_n = 1'b1;
    drive16(OP_PASS_B, 16'h1234, 16'h00FF, 1'b0, 1'b0);
    @(negedge clk);
    check("mrst_pass_valid", 32'(ov16), 32'd1);
    check("mrst_pass_data", 32'(d16), 32'h00FF);
    drive16(OP_XOR, 16'h00F0, 16'h000F, 1'b0, 1'b0);
    @(negedge clk);
    v16 = 1'b0;
    check("mrst_idle_data", 32'(d16), 32'h00FF);

`ifdef BITWISE_ACC_FLAGS_EN
    drive16(OP_NOT_B, 16'h1234, 16'h0000, 1'b0, 1'b0);
    @(negedge clk);
    v16 = 1'b0;
    check("notb_data", 32'(d16), 32'hFFFF);
    check("notb_zr", 32'(zr16), 32'd0);
    check("notb_ng", 32'(ng16), 32'd1);
`endif

    // WIDTH=8 sweep: every op, pass-through vs single-beat packet
    for (int op = 0; op < 8; op++) begin
      for (int k = 0; k < 4; k++) begin
        logic [7:0] sa, sb, se;
        sa = 8'($urandom); sb = 8'($urandom);
        se = 8'(ref_op(3'(op), {8'h00, sa}, {8'h00, sb}));
        v8 = 1'b1; op8 = 3'(op); a8 = sa; b8 = sb; acc8 = 1'b0; last8 = 1'b0;
        @(negedge clk);
        check($sformatf("sw_op%0d_pass", op), 32'(d8), 32'(se));
        acc8 = 1'b1; last8 = 1'b1;
        @(negedge clk);
        v8 = 1'b0;
        check($sformatf("sw_op%0d_single", op), 32'(d8), 32'(se));
        check($sformatf("sw_op%0d_valid", op), 32'(ov8), 32'd1);
      end
    end

    // Randomized handshake against packet-level model
    m_valid = 1'b0; m_in_pkt = 1'b0; m_data = '0; m_first = '0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      @(negedge clk);
      check("rnd_valid", 32'(ov8), 32'(m_valid));
      if (m_valid) begin
        check("rnd_data", 32'(d8), 32'(m_data));
`ifdef BITWISE_ACC_FLAGS_EN
        check("rnd_zr", 32'(zr8), 32'(m_data == 8'h00));
        check("rnd_ng", 32'(ng8), 32'(m_data[7]));
`endif
      end
      ordy8 = ($urandom_range(0, 3) != 0);
      v8    = ($urandom_range(0, 3) != 0);
      a8    = 8'($urandom); b8 = 8'($urandom); op8 = 3'($urandom);
      acc8  = ($urandom_range(0, 2) == 0);
      last8 = ($urandom_range(0, 2) == 0);
      #1;
      check("rnd_ready", 32'(r8), 32'(!m_valid || ordy8));
      accept  = v8 && (!m_valid || ordy8);
      produce = 1'b0;
      res     = '0;
      if (accept) begin
        if (!m_in_pkt) begin
          if (acc8 && !last8) begin
            m_in_pkt = 1'b1;
            m_first  = 8'(ref_op(op8, {8'h00, a8}, {8'h00, b8}));
            q_op.delete(); q_b.delete();
          end else begin
            produce = 1'b1;
            res     = 8'(ref_op(op8, {8'h00, a8}, {8'h00, b8}));
          end
        end else begin
          q_op.push_back(op8); q_b.push_back(b8);
          if (last8) begin
            res = m_first;
            foreach (q_op[j]) res = 8'(ref_op(q_op[j], {8'h00, res}, {8'h00, q_b[j]}));
            produce  = 1'b1;
            m_in_pkt = 1'b0;
          end
        end
      end
      if (produce) begin
        m_valid = 1'b1;
        m_data  = res;
      end else if (ordy8) begin
        m_valid = 1'b0;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
